seq1010_rr_scheduler: RTL and testbench
=======================================

# seq1010_rr_scheduler

Round-robin scheduler that shares a single bit-serial "1010" Mealy detector between two word-wide requesters. It accepts one word at a time over a valid/ready handshake and shifts the word MSB-first through the detector. When the shift completes, it reports the number of non-overlapping 1010 matches, tagged with the requester ID. It sits between the packet-producing front ends and the match-statistics logic.

## Interface
- DW, 8, word width in bits; legal values 8, 16, 32.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  2  bit i: requester i presents a word.
- req_data0  input  DW  requester 0 word.
- req_data1  input  DW  requester 1 word.
- req_ready  output  2  bit i: requester i's word is accepted this cycle; at most one bit is high.
- res_valid  output  1  one-cycle pulse; result fields are valid.
- res_id  output  1  requester whose word produced the result.
- res_count  output  4  number of non-overlapping 1010 matches in the word.
- res_hit  output  1  res_count != 0.
- busy  output  1  high in SHIFT and REPORT.

## Operation
- FSM states:
  - IDLE: no word held.
  - SHIFT: word being fed to the detector.
  - REPORT: result being presented.
- IDLE behaviour:
  - The grant is combinational from req_valid and the round-robin pointer `last`.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester != last is granted.
  - req_ready = grant, asserted only in IDLE.
  - Handshake: req_valid[i] && req_ready[i]. On the handshake edge:
    - latch the word into shreg and i into id;
    - set last = i, bitcnt = DW-1, detector state = S0, count = 0;
    - go to SHIFT.
- SHIFT behaviour:
  - Each cycle feeds bit b = shreg[bitcnt] to the detector.
  - count increments when the Mealy output is 1.
  - bitcnt decrements.
  - When bitcnt == 0, the final bit is processed and the FSM goes to REPORT.
- REPORT behaviour:
  - res_valid = 1 for exactly one cycle, then IDLE.
  - res_count, res_hit and res_id are driven from registered values.
  - These fields hold their values until the next REPORT.
- Detector (internal, 2-bit state, Mealy output m):
  - S0: b=1 → S1, b=0 → S0; m=0.
  - S1: b=1 → S1, b=0 → S2; m=0.
  - S2: b=1 → S3, b=0 → S0; m=0.
  - S3: b=1 → S1 with m=0; b=0 → S0 with m=1.
  - Matching is non-overlapping: the detector returns to S0 after each match.
- Detector scope:
  - The detector is re-initialised to S0 for every word.
  - Matches never span words or requesters.
- Arithmetic:
  - count is 4 bits; the maximum is DW/4 = 8 for DW=32, so no saturation is needed.
- Requester rules:
  - A requester holds req_data stable while valid and not ready.
  - Dropping valid before a grant is legal and has no effect.
  - A new valid arriving in SHIFT or REPORT waits; req_ready stays 0.
- No backpressure on the result: downstream must take res_valid when it occurs.

## Timing
- Reset (rst low, asynchronous, immediate):
  - FSM = IDLE, last = 1 (requester 0 wins first), detector = S0.
  - count = 0, res_valid = 0, res_id = 0, res_count = 0, res_hit = 0, busy = 0.
  - req_ready follows the IDLE grant logic.
- Handshake on edge T:
  - The DW bits are processed on edges T+1 … T+DW.
  - res_valid is high in the cycle after edge T+DW+1.
  - The earliest next handshake is edge T+DW+2.
  - Throughput is one word per DW+2 cycles.
- busy is high from the cycle after the handshake through the REPORT cycle.
- Reset during SHIFT or REPORT:
  - The word is discarded and no res_valid is produced.
  - The pointer returns to last = 1.
- Simultaneous valid on both requesters with the pointer at last:
  - The grant goes to the other requester.
  - Under continuous dual requests, grants alternate 0,1,0,1,….

## Test plan
- Reset, then req_valid=2'b01, req_data0=8'hAA (10101010):
  - req_ready=2'b01 on the first cycle;
  - res_valid 9 cycles later with res_id=0, res_count=2, res_hit=1.
- Non-overlap check: requester 1 sends 8'hA8 → res_id=1, res_count=1 (an overlapping detector would give 2).
- Mixed words, one per test:
  - 8'h5A → res_count=1;
  - 8'h50 → res_count=1;
  - 8'hFF → res_count=0, res_hit=0;
  - 8'h00 → res_count=0, res_hit=0.
- Both req_valid held high for 4 words:
  - grants occur in order 0,1,0,1;
  - handshakes are exactly 10 cycles apart;
  - req_ready=0 throughout SHIFT and REPORT.
- Requester 0 sends 8'hAA, and rst is pulsed low at bit 4 of SHIFT:
  - all outputs clear immediately and no res_valid appears;
  - a later request from requester 0 is granted first and yields count 2.
- DW=32, word 32'hAAAAAAAA → res_count=8, res_valid 33 cycles after the handshake.

Source files
------------

// File: rtl/seq1010_rr_scheduler.sv
// seq1010_rr_scheduler: shares one bit-serial "1010" Mealy detector between two word requesters
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   req_valid  per-requester word-present flags
//   req_data0  requester 0 word
//   req_data1  requester 1 word
//   req_ready  one-hot accept, only while idle
//   res_valid  one-cycle result pulse
//   res_id     requester that produced the result
//   res_count  non-overlapping 1010 matches in the word
//   res_hit    res_count != 0
//   busy       word in flight (shifting or reporting)
module seq1010_rr_scheduler #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    output logic [1:0]    req_ready,
    output logic          res_valid,
    output logic          res_id,
    output logic [3:0]    res_count,
    output logic          res_hit,
    output logic          busy
);
    localparam int BW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    state_t        state, state_next;
    det_t          det, det_next;
    logic          last;
    logic [DW-1:0] shreg;
    logic [BW-1:0] bitcnt;
    logic          id;
    logic [3:0]    count;
    logic [1:0]    grant;
    logic          bit_in;
    logic          m;

    always_comb begin
        // with both valid, the one that did not win last time goes next
        grant      = (req_valid == 2'b11) ? (last ? 2'b01 : 2'b10) : req_valid;
        req_ready  = (state == IDLE) ? grant : 2'b00;
        busy       = state != IDLE;
        bit_in     = shreg[bitcnt];
        m          = 1'b0;
        det_next   = S0;
        case (det)
            S0: det_next = bit_in ? S1 : S0;
            S1: det_next = bit_in ? S1 : S2;
            S2: det_next = bit_in ? S3 : S0;
            S3: begin
                // a completed match drops back to S0 so matches never overlap
                det_next = bit_in ? S1 : S0;
                m        = !bit_in;
            end
            default: det_next = S0;
        endcase
        state_next = state;
        case (state)
            IDLE:    state_next = (|req_ready) ? SHIFT : IDLE;
            SHIFT:   state_next = (bitcnt == '0) ? REPORT : SHIFT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last      <= 1'b1;
            det       <= S0;
            shreg     <= '0;
            bitcnt    <= '0;
            id        <= 1'b0;
            count     <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_count <= '0;
            res_hit   <= 1'b0;
        end else begin
            // the pulse follows the REPORT cycle, when the result registers have just loaded
            res_valid <= state == REPORT;
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        shreg  <= req_ready[1] ? req_data1 : req_data0;
                        id     <= req_ready[1];
                        last   <= req_ready[1];
                        bitcnt <= BW'(DW - 1);
                        det    <= S0;
                        count  <= '0;
                    end
                end
                SHIFT: begin
                    det    <= det_next;
                    count  <= count + 4'(m);
                    bitcnt <= bitcnt - 1'b1;
                end
                REPORT: begin
                    res_id    <= id;
                    res_count <= count;
                    res_hit   <= count != 4'd0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq1010_rr_scheduler.sv
// tb_seq1010_rr_scheduler: directed bench with a cycle-level reference model for the 1010 scheduler
module tb_seq1010_rr_scheduler;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [7:0]  req_data0 = 8'h00;
    logic [7:0]  req_data1 = 8'h00;
    logic [1:0]  req_ready;
    logic        res_valid;
    logic        res_id;
    logic [3:0]  res_count;
    logic        res_hit;
    logic        busy;

    logic [1:0]  v32 = 2'b00;
    logic [31:0] d32 = 32'h0;
    logic [1:0]  rdy32;
    logic        rv32;
    logic        rid32;
    logic [3:0]  rcnt32;
    logic        rhit32;
    logic        busy32;

    seq1010_rr_scheduler #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
        .res_hit(res_hit), .busy(busy)
    );

    seq1010_rr_scheduler #(.DW(32)) dut32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_data0(d32), .req_data1(32'h0),
        .req_ready(rdy32), .res_valid(rv32), .res_id(rid32), .res_count(rcnt32),
        .res_hit(rhit32), .busy(busy32)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // greedy leftmost scan from the MSB; a match consumes its four bits
    function automatic int cnt1010(input logic [31:0] w, input int n);
        int c = 0;
        int i = n - 1;
        while (i >= 3) begin
            if (w[i -: 4] == 4'b1010) begin
                c++;
                i -= 4;
            end else begin
                i--;
            end
        end
        return c;
    endfunction

    // reference model: handshakes and result times in terms of clock-edge numbers
    int   m_last = 1, m_free_at = 0, m_due = -1, m_pid = 0, m_pcnt = 0;
    int   e_id = 0, e_cnt = 0;
    logic [1:0] gnt, exp_ready;

    always @(negedge clk) begin
        if (!rst) begin
            m_last = 1; m_free_at = 0; m_due = -1; e_id = 0; e_cnt = 0;
        end else if (cyc == m_due) begin
            e_id = m_pid; e_cnt = m_pcnt;
        end
        gnt       = (req_valid == 2'b11) ? (m_last == 1 ? 2'b01 : 2'b10) : req_valid;
        exp_ready = (cyc >= m_free_at) ? gnt : 2'b00;
        chk("req_ready", int'(req_ready), int'(exp_ready));
        chk("res_valid", int'(res_valid), int'(rst && cyc == m_due));
        chk("busy",      int'(busy),      int'(cyc < m_free_at));
        chk("res_id",    int'(res_id),    e_id);
        chk("res_count", int'(res_count), e_cnt);
        chk("res_hit",   int'(res_hit),   int'(e_cnt != 0));
        if (rst && exp_ready != 2'b00) begin
            m_last    = exp_ready[1] ? 1 : 0;
            m_pid     = m_last;
            m_pcnt    = cnt1010(32'(exp_ready[1] ? req_data1 : req_data0), DW);
            m_free_at = cyc + 1 + DW + 1;
            m_due     = cyc + 1 + DW + 1;
        end
    end

    // event logs used by the literal checks
    int hs_edge[$], hs_id[$], rs_edge[$];
    int hs32 = -1, rs32 = -1;

    always @(negedge clk) begin
        if (rst && (req_valid & req_ready) != 2'b00) begin
            hs_edge.push_back(cyc + 1);
            hs_id.push_back(int'(req_ready[1]));
        end
        if (res_valid) rs_edge.push_back(cyc);
        if (rst && (v32 & rdy32) != 2'b00) hs32 = cyc + 1;
        if (rv32) rs32 = cyc;
    end

    task automatic wait_hs(input int target);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (hs_edge.size() < target && n < 60);
        chk("hs_timeout", int'(hs_edge.size() >= target), 1);
    endtask

    task automatic send(input int r, input logic [7:0] w, input int ecnt);
        int base;
        @(posedge clk); #1;
        if (r == 1) req_data1 = w; else req_data0 = w;
        req_valid[r] = 1'b1;
        base = hs_edge.size();
        #1 chk("ready_first", int'(req_ready), r == 1 ? 2 : 1);
        wait_hs(base + 1);
        req_valid = 2'b00;
        repeat (DW + 4) @(posedge clk);
        #1;
        chk("lit_id",    int'(res_id),    r);
        chk("lit_count", int'(res_count), ecnt);
        chk("lit_hit",   int'(res_hit),   int'(ecnt != 0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base, nres, n;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy",  int'(busy),      0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_count", int'(res_count), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        send(0, 8'hAA, 2);
        chk("lat_first", rs_edge[rs_edge.size()-1] - hs_edge[hs_edge.size()-1], 9);
        send(1, 8'hA8, 1);
        send(0, 8'h5A, 1);
        send(1, 8'h50, 1);
        send(0, 8'hFF, 0);
        send(1, 8'h00, 0);

        // continuous dual requests
        @(posedge clk); #1;
        req_data0 = 8'h5A;
        req_data1 = 8'hAA;
        base = hs_edge.size();
        req_valid = 2'b11;
        wait_hs(base + 4);
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) chk("rr_order", hs_id[base + k], k % 2);
        for (int k = 0; k < 3; k++) chk("rr_gap", hs_edge[base + k + 1] - hs_edge[base + k], 10);
        repeat (DW + 4) @(posedge clk);
        #1 chk("rr_last_count", int'(res_count), 2);

        // reset in the middle of a shift
        @(posedge clk); #1;
        req_data0 = 8'hAA;
        req_valid = 2'b01;
        base = hs_edge.size();
        wait_hs(base + 1);
        req_valid = 2'b00;
        nres = rs_edge.size();
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_busy",  int'(busy),      0);
        chk("mid_valid", int'(res_valid), 0);
        chk("mid_count", int'(res_count), 0);
        chk("mid_hit",   int'(res_hit),   0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        chk("mid_no_result", rs_edge.size() - nres, 0);

        @(posedge clk); #1;
        req_data0 = 8'hAA;
        req_data1 = 8'h00;
        base = hs_edge.size();
        req_valid = 2'b11;
        wait_hs(base + 1);
        req_valid = 2'b00;
        chk("post_rst_grant", hs_id[hs_edge.size()-1], 0);
        repeat (DW + 4) @(posedge clk);
        #1 chk("post_rst_count", int'(res_count), 2);

        // 32-bit instance
        @(posedge clk); #1;
        d32 = 32'hAAAAAAAA;
        v32 = 2'b01;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (hs32 < 0 && n < 60);
        v32 = 2'b00;
        chk("hs32_seen", int'(hs32 >= 0), 1);
        repeat (40) @(posedge clk);
        #1;
        chk("w32_count", int'(rcnt32), 8);
        chk("w32_hit",   int'(rhit32), 1);
        chk("w32_id",    int'(rid32),  0);
        chk("w32_lat",   rs32 - hs32,  33);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
